// File: rtl/result_collector.sv
// result_collector: gathers result beats from the SMVM datapath into a
// show-ahead FIFO and presents them to a downstream consumer with
// valid/ready handshaking. A job is started with a row count; the block
// counts incoming beats, stores what fits, flags drops in a sticky
// overflow bit, drains the FIFO and then pulses done for one cycle.
//
// Optional build macro: RESULT_COLLECTOR_ROW_TAG_EN
//   When defined, every FIFO entry also carries the 0-based receive count
//   at acceptance, presented on o_row for the head entry. When undefined,
//   entries are data only and o_row is tied to zero.
module result_collector #(
    parameter int DW    = 12,
    parameter int DEPTH = 16,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] rows_cfg,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [RW-1:0] o_row,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef RESULT_COLLECTOR_ROW_TAG_EN
    localparam int EW = DW + RW;
`else
    localparam int EW = DW;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0] RCV_ONE    = RW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [RW-1:0] rows_reg;
    logic [RW-1:0] rcv_cnt_reg;
    logic          overflow_reg;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic [EW-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Handshake / FIFO control decode
    // ------------------------------------------------------------------
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          beat;
    logic          push;
    logic          drop;
    logic          start_job;
    logic [RW-1:0] rcv_cnt_inc;
    logic          last_beat;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

    assign fifo_empty  = (count_reg == '0);
    assign fifo_full   = (count_reg == FULL_COUNT);

    // A pop needs a visible head, so a beat pushed into an empty FIFO can
    // never leave in the same cycle it arrives.
    assign pop         = !fifo_empty && o_ready;

    // Only beats seen while collecting are counted or stored.
    assign beat        = (state_reg == S_COLLECT) && in_valid;

    // When full, a simultaneous pop frees the slot the beat needs.
    assign push        = beat && (!fifo_full || pop);
    assign drop        = beat && fifo_full && !pop;

    assign start_job   = (state_reg == S_IDLE) && start;
    assign rcv_cnt_inc = rcv_cnt_reg + RCV_ONE;
    assign last_beat   = beat && (rcv_cnt_inc == rows_reg);

`ifdef RESULT_COLLECTOR_ROW_TAG_EN
    // Tag is the receive count before this beat, i.e. the 0-based row index.
    assign wr_entry = {rcv_cnt_reg, in_data};
`else
    assign wr_entry = in_data;
`endif

    assign head_entry = mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Next-state logic for the job sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (rows_cfg == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_beat) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Job configuration: row count captured only when a job is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_reg <= '0;
        end else if (start_job) begin
            rows_reg <= rows_cfg;
        end
    end

    // Receive counter: cleared on launch, bumped by every collected beat
    // whether it was stored or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcv_cnt_reg <= '0;
        end else if (start_job) begin
            rcv_cnt_reg <= '0;
        end else if (beat) begin
            rcv_cnt_reg <= rcv_cnt_inc;
        end
    end

    // Sticky overflow flag: set on any dropped beat, cleared on launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (start_job) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // Write pointer wraps naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        end
    end

    // Read pointer wraps naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
        end else if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked
    // whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid  = !fifo_empty;
    assign o_data   = fifo_empty ? '0 : head_entry[DW-1:0];

`ifdef RESULT_COLLECTOR_ROW_TAG_EN
    assign o_row    = fifo_empty ? '0 : head_entry[EW-1:DW];
`else
    assign o_row    = '0;
`endif

    assign busy     = (state_reg == S_COLLECT) || (state_reg == S_DRAIN);
    assign done     = (state_reg == S_DONE);
    assign overflow = overflow_reg;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DW, default 12, width of one result word from the SMVM datapath.
REQ-002 Parameter DEPTH, default 16, result FIFO entries (power of two).
REQ-003 Parameter RW, default 9, width of row count and row index.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a collection job.
REQ-007 rows_cfg  input  RW  expected number of result rows; sampled on start.
REQ-008 in_valid  input  1  result beat valid, driven by the SMVM out_valid.
REQ-009 in_data  input  DW  result value, driven by the SMVM data_out.
REQ-010 o_valid  output  1  FIFO head valid.
REQ-011 o_ready  input  1  downstream consumer ready.
REQ-012 o_data  output  DW  FIFO head value.
REQ-013 o_row  output  RW  row index of FIFO head (see Configuration).
REQ-014 busy  output  1  high in COLLECT or DRAIN.
REQ-015 done  output  1  one-cycle pulse at job completion.
REQ-016 overflow  output  1  sticky; a beat was dropped because the FIFO was full.

Function
REQ-017 FSM states IDLE, COLLECT, DRAIN, DONE; IDLE->COLLECT on start with rows_cfg!=0; IDLE->DONE on start with rows_cfg==0.
REQ-018 start outside IDLE shall be ignored; rows_cfg is not re-sampled.
REQ-019 start from IDLE shall clear overflow and the receive counter rcv_cnt (RW bits).
REQ-020 In COLLECT every in_valid beat shall increment rcv_cnt, whether or not it is stored.
REQ-021 In COLLECT an in_valid beat shall be written when FIFO not full, or when full and a pop occurs in the same cycle (count unchanged).
REQ-022 An in_valid beat arriving full without a simultaneous pop shall be dropped and set overflow.
REQ-023 COLLECT->DRAIN in the cycle after the beat that makes rcv_cnt equal rows_cfg.
REQ-024 in_valid in IDLE, DRAIN or DONE shall be ignored (not stored, not counted).
REQ-025 DRAIN->DONE when FIFO is empty; DONE->IDLE unconditionally after one cycle; done high only in DONE.
REQ-026 FIFO is show-ahead: o_valid = not empty, o_data/o_row = head entry; pop on o_valid & o_ready.
REQ-027 Latency: beat written at edge t appears with o_valid high in the cycle after t; a push into an empty FIFO is never popped in the same cycle.
REQ-028 FIFO read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-029 o_data shall be 0 when o_valid is low.
REQ-030 Output order equals acceptance order; no reordering or combining.

Reset
REQ-031 On rst_n low, at any time including mid-job: state IDLE, FIFO empty, rcv_cnt 0, o_valid 0, o_data 0, o_row 0, busy 0, done 0, overflow 0.
REQ-032 A job interrupted by reset is abandoned; no done pulse is generated for it.

Configuration
REQ-033 Macro RESULT_COLLECTOR_ROW_TAG_EN: when defined, each FIFO entry stores rcv_cnt value at acceptance (0-based) alongside data and o_row presents it for the head.
REQ-034 Without RESULT_COLLECTOR_ROW_TAG_EN, FIFO stores DW bits only and o_row is tied to 0; all other behaviour identical.

Verification
REQ-035 start, rows_cfg=3; beats 0x011,0x022,0x033 with o_ready=1 -> o_data 0x011,0x022,0x033 each one cycle after its beat, then done one pulse; with tag EN o_row 0,1,2.
REQ-036 start, rows_cfg=20, o_ready=0, 20 consecutive beats -> 16 stored, overflow=1, state DRAIN; raise o_ready -> 16 pops of first 16 values, then done.
REQ-037 FIFO full, in_valid and pop in same cycle -> beat accepted, occupancy stays 16, overflow stays 0.
REQ-038 start with rows_cfg=0 -> done pulse 1 cycle later, busy never high, o_valid 0.
REQ-039 rows_cfg=4, 2 beats accepted, rst_n pulsed low -> all outputs 0 immediately; later in_valid ignored until next start; no done.
REQ-040 Beat in IDLE and a second start during COLLECT -> neither stored nor counted; job completes after original rows_cfg beats.
